// File: rtl/sudoku_grid_loader_if.sv
// Cell-stream, grid-handoff and status signals between a producer/consumer
// and the sudoku grid loader.
interface sudoku_grid_loader_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 cell_valid;
  logic [WIDTH-1:0]     cell_data;
  logic                 cell_ready;
  logic                 grid_ack;
  logic                 grid_valid;
  logic [81*WIDTH-1:0]  puzzle_ans;
  logic [3:0]           row;
  logic [3:0]           col;
  logic [6:0]           blank_count;
  logic                 range_err;

  modport master (
    output start, cell_valid, cell_data, grid_ack,
    input  cell_ready, grid_valid, puzzle_ans, row, col, blank_count, range_err
  );

  modport slave (
    input  start, cell_valid, cell_data, grid_ack,
    output cell_ready, grid_valid, puzzle_ans, row, col, blank_count, range_err
  );
endinterface

// File: rtl/sudoku_grid_loader.sv
// Collects 81 sudoku cells in row-major order into a flat grid register,
// tracking blank cells and out-of-range values, then holds it until acked.
module sudoku_grid_loader #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sudoku_grid_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  localparam logic [WIDTH-1:0] MAX_HEX = WIDTH'(9);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t      state_reg, state_next;
  logic [3:0]  row_reg, row_next;
  logic [3:0]  col_reg, col_next;
  logic [6:0]  blank_reg, blank_next;
  logic        err_reg, err_next;
  logic        clear;
  logic        wr_en;
  logic        bad_value;
  logic [6:0]  wr_idx;

  assign wr_idx = 7'(row_reg) * 7'd9 + 7'(col_reg);

  // One-hot encoding allows zero (blank) or exactly one set bit.
  generate
    if (WIDTH == 9) begin : g_onehot
      assign bad_value = (|bus.cell_data) && (|(bus.cell_data & (bus.cell_data - ONE)));
    end else begin : g_hex
      assign bad_value = bus.cell_data > MAX_HEX;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    blank_next = blank_reg;
    err_next   = err_reg;
    clear      = 1'b0;
    wr_en      = 1'b0;
    if (bus.start) begin
      state_next = LOAD;
      row_next   = 4'd0;
      col_next   = 4'd0;
      blank_next = 7'd0;
      err_next   = 1'b0;
      clear      = 1'b1;
    end else begin
      case (state_reg)
        LOAD: begin
          if (bus.cell_valid) begin
            wr_en = 1'b1;
            if (bus.cell_data == '0 && blank_reg < 7'd81)
              blank_next = blank_reg + 7'd1;
            if (bad_value)
              err_next = 1'b1;
            if (col_reg == 4'd8) begin
              col_next = 4'd0;
              if (row_reg == 4'd8) begin
                row_next   = 4'd0;
                state_next = HOLD;
              end else begin
                row_next = row_reg + 4'd1;
              end
            end else begin
              col_next = col_reg + 4'd1;
            end
          end
        end
        HOLD: begin
          if (bus.grid_ack)
            state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= 4'd0;
      col_reg   <= 4'd0;
      blank_reg <= 7'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      blank_reg <= blank_next;
      err_reg   <= err_next;
    end
  end

  // Each cell is its own register so the whole grid is visible at once.
  generate
    for (genvar gi = 0; gi < 81; gi++) begin : g_cell
      logic [WIDTH-1:0] cell_reg;
      always_ff @(posedge clk) begin
        if (rst || clear)
          cell_reg <= '0;
        else if (wr_en && wr_idx == 7'(gi))
          cell_reg <= bus.cell_data;
      end
      assign bus.puzzle_ans[gi*WIDTH +: WIDTH] = cell_reg;
    end
  endgenerate

  assign bus.cell_ready  = (state_reg == LOAD);
  assign bus.grid_valid  = (state_reg == HOLD);
  assign bus.row         = row_reg;
  assign bus.col         = col_reg;
  assign bus.blank_count = blank_reg;
  assign bus.range_err   = err_reg;
endmodule

// File: tb/tb_sudoku_grid_loader.sv
// Directed and randomized checks of sudoku_grid_loader against an
// index-based reference model of the grid load protocol.
module tb_sudoku_grid_loader;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  sudoku_grid_loader_if #(.WIDTH(W)) bus ();
  sudoku_grid_loader #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 load, 2 hold; next cell index 0..80.
  int m_state;
  int m_idx;
  int m_blank;
  bit m_err;
  int m_cells [81];

  function automatic logic [323:0] m_grid();
    logic [323:0] g;
    g = '0;
    for (int i = 0; i < 81; i++) g[i*4 +: 4] = 4'(m_cells[i]);
    return g;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_state = 0; m_idx = 0; m_blank = 0; m_err = 0;
      for (int i = 0; i < 81; i++) m_cells[i] = 0;
    end else if (bus.start) begin
      m_state = 1; m_idx = 0; m_blank = 0; m_err = 0;
      for (int i = 0; i < 81; i++) m_cells[i] = 0;
    end else if (m_state == 1 && bus.cell_valid) begin
      m_cells[m_idx] = int'(bus.cell_data);
      if (bus.cell_data == 0) m_blank = (m_blank + 1 > 81) ? 81 : m_blank + 1;
      if (int'(bus.cell_data) > 9) m_err = 1;
      m_idx++;
      if (m_idx == 81) begin
        m_idx = 0;
        m_state = 2;
      end
    end else if (m_state == 2 && bus.grid_ack) begin
      m_state = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [323:0] obs, input logic [323:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cell_ready",  324'(bus.cell_ready),  324'(m_state == 1));
    chk("grid_valid",  324'(bus.grid_valid),  324'(m_state == 2));
    chk("row",         324'(bus.row),         324'(m_idx / 9));
    chk("col",         324'(bus.col),         324'(m_idx % 9));
    chk("blank_count", 324'(bus.blank_count), 324'(m_blank));
    chk("range_err",   324'(bus.range_err),   324'(m_err));
    chk("puzzle_ans",  bus.puzzle_ans,        m_grid());
  endtask

  task automatic drive(input logic s, input logic v, input logic [3:0] d, input logic a);
    bus.start      = s;
    bus.cell_valid = v;
    bus.cell_data  = d;
    bus.grid_ack   = a;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic load_cell(input logic [3:0] d);
    drive(1'b0, 1'b1, d, 1'b0);
    cycle();
  endtask

  task automatic start_pulse();
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    cycle();
  endtask

  initial begin
    logic [3:0] d;
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    m_state = 0; m_idx = 0; m_blank = 0; m_err = 0;
    for (int i = 0; i < 81; i++) m_cells[i] = 0;
    cycle();
    cycle();
    rst = 1'b0;
    check_all();

    // Full load of 1..9 repeating, back-to-back.
    start_pulse();
    for (int i = 0; i < 81; i++) begin
      load_cell(4'((i % 9) + 1));
      if (i < 80) chk("no_early_valid", 324'(bus.grid_valid), 324'(0));
    end
    chk("valid_after_81", 324'(bus.grid_valid), 324'(1));
    chk("cell0", 324'(bus.puzzle_ans[3:0]), 324'(1));
    chk("cell80", 324'(bus.puzzle_ans[323:320]), 324'(9));
    chk("blank_zero", 324'(bus.blank_count), 324'(0));

    // HOLD ignores cell_valid until acked.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'(i), 1'b0);
      cycle();
      chk("hold_valid", 324'(bus.grid_valid), 324'(1));
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    cycle();
    chk("ack_to_idle", 324'(bus.grid_valid), 324'(0));
    drive(1'b0, 1'b1, 4'd3, 1'b1);
    cycle();
    cycle();

    // Zeros at 0, 9, 40, 79, 80.
    start_pulse();
    for (int i = 0; i < 81; i++) begin
      if (i == 0 || i == 9 || i == 40 || i == 79 || i == 80) d = 4'd0;
      else d = 4'($urandom_range(1, 9));
      load_cell(d);
    end
    chk("five_blanks", 324'(bus.blank_count), 324'(5));
    chk("zero_cell40", 324'(bus.puzzle_ans[163:160]), 324'(0));
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    cycle();

    // start during LOAD at index 30 wins over the handshake.
    start_pulse();
    for (int i = 0; i < 30; i++) load_cell(4'($urandom_range(1, 9)));
    drive(1'b1, 1'b1, 4'd7, 1'b0);
    cycle();
    chk("restart_grid", bus.puzzle_ans, 324'(0));
    chk("restart_load", 324'(bus.cell_ready), 324'(1));

    // Out-of-range value at index 10 stays flagged.
    for (int i = 0; i < 10; i++) load_cell(4'($urandom_range(1, 9)));
    load_cell(4'hC);
    chk("err_set", 324'(bus.range_err), 324'(1));
    chk("cell10", 324'(bus.puzzle_ans[43:40]), 324'(12));
    for (int i = 11; i < 81; i++) load_cell(4'($urandom_range(0, 9)));
    chk("err_sticky", 324'(bus.range_err), 324'(1));
    start_pulse();
    chk("err_cleared", 324'(bus.range_err), 324'(0));

    // All-zero load drives blank_count to its maximum.
    for (int i = 0; i < 81; i++) load_cell(4'd0);
    chk("blank_81", 324'(bus.blank_count), 324'(81));

    // rst mid-load dominates start and handshake.
    start_pulse();
    for (int i = 0; i < 50; i++) load_cell(4'($urandom_range(1, 9)));
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd5, 1'b0);
    cycle();
    rst = 1'b0;
    chk("rst_grid", bus.puzzle_ans, 324'(0));
    chk("rst_ready", 324'(bus.cell_ready), 324'(0));
    for (int i = 0; i < 3; i++) load_cell(4'd4);
    chk("idle_no_accept", bus.puzzle_ans, 324'(0));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 8,
            ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
